// File: rtl/clock_sel_ctrl_pkg.sv
// clock_ctrl_pkg: FSM states, clock-source encodings, register address and source decode shared by the clock-select control slice
package clock_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, GATE, SETTLE1, APPLY, SETTLE2, RESTORE} state_t;
  localparam logic [2:0] CLK_PLL1 = 3'b001;
  localparam logic [2:0] CLK_EXT = 3'b101;
  localparam logic [7:0] REG_CLKSETTINGS = 8'h0C;
  function automatic logic src_ext(input logic [4:0] r, input logic j16);
    return r[2:0] == CLK_PLL1 ? 1'b0 : r[2:0] == CLK_EXT ? 1'b1 : ~r[0] & j16;
  endfunction
endpackage

// File: rtl/clock_sel_ctrl_if.sv
// clock_sel_ctrl_if: USB register bus (reg_addr/reg_write/reg_read/reg_datai from master, reg_datao from slave)
interface clock_sel_ctrl_if;
  logic [7:0] reg_addr;
  logic reg_write;
  logic reg_read;
  logic [7:0] reg_datai;
  logic [7:0] reg_datao;
  modport master (output reg_addr, reg_write, reg_read, reg_datai, input reg_datao);
  modport slave (input reg_addr, reg_write, reg_read, reg_datai, output reg_datao);
endinterface

// File: rtl/clock_sel_ctrl_dip_debounce.sv
// dip_debounce: 2-FF synchroniser plus stability counter; ports clk, rst_n, raw (async DIP in), db (accepted level)
module dip_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db
);
  logic [1:0] sync;
  logic [CNT_W-1:0] cnt;
  logic last;
  assign last = cnt == CNT_W'(DEBOUNCE_CYCLES - 16'd1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync <= '0;
      cnt <= '0;
      db <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      cnt <= (sync[1] == db || last) ? '0 : cnt + 1'b1;
      if (sync[1] != db && last) db <= sync[1];
    end
endmodule

// File: rtl/clock_sel_ctrl.sv
// clock_sel_ctrl: clock-settings register, DIP debounce and gated source-switch sequencer; ports usb_clk, rst_n, bus (slave), j16_raw/k16_raw in, O_clock_reg/O_j16_sel/O_k16_sel/O_busy/O_switch_count out
module clock_sel_ctrl
  import clock_ctrl_pkg::*;
#(
  parameter logic [7:0] REG_ADDR = REG_CLKSETTINGS,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [7:0] SETTLE_CYCLES = 8'd16,
  parameter int CNT_W = 16
) (
  input  logic usb_clk,
  input  logic rst_n,
  clock_sel_ctrl_if.slave bus,
  input  logic j16_raw,
  input  logic k16_raw,
  output logic [4:0] O_clock_reg,
  output logic O_j16_sel,
  output logic O_k16_sel,
  output logic O_busy,
  output logic [7:0] O_switch_count
);
  state_t state, state_d;
  logic [4:0] target, clock_reg_d;
  logic j16_db, k16_db, j16_d, k16_d, new_src, new_src_d, settle_done, hit_w, hit_r;
  logic [7:0] cnt, cnt_d, count_d;
  logic unused_bits;
  assign unused_bits = ^bus.reg_datai[7:5];
  assign hit_w = bus.reg_write && bus.reg_addr == REG_ADDR;
  assign hit_r = bus.reg_read && bus.reg_addr == REG_ADDR;
  assign settle_done = cnt == SETTLE_CYCLES - 8'd1;
  dip_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_j16 (
    .clk(usb_clk), .rst_n(rst_n), .raw(j16_raw), .db(j16_db)
  );
  dip_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_k16 (
    .clk(usb_clk), .rst_n(rst_n), .raw(k16_raw), .db(k16_db)
  );
  always_ff @(posedge usb_clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      new_src <= 1'b0;
      target <= 5'b00001;
      O_clock_reg <= 5'b00001;
      O_j16_sel <= 1'b0;
      O_k16_sel <= 1'b0;
      O_busy <= 1'b0;
      O_switch_count <= '0;
      bus.reg_datao <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      new_src <= new_src_d;
      if (hit_w) target <= bus.reg_datai[4:0];
      O_clock_reg <= clock_reg_d;
      O_j16_sel <= j16_d;
      O_k16_sel <= k16_d;
      O_busy <= state_d != IDLE;
      O_switch_count <= count_d;
      bus.reg_datao <= hit_r ? {O_busy, 2'b00, target} : 8'h00;
    end
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    new_src_d = new_src;
    clock_reg_d = O_clock_reg;
    j16_d = O_j16_sel;
    k16_d = O_k16_sel;
    count_d = O_switch_count;
    case (state)
      IDLE:
        if (src_ext(target, j16_db) != src_ext(O_clock_reg, O_j16_sel)) state_d = GATE;
        else begin
          clock_reg_d = target;
          j16_d = j16_db;
          k16_d = k16_db;
        end
      GATE: begin
        clock_reg_d = {2'b00, src_ext(O_clock_reg, O_j16_sel) ? CLK_EXT : CLK_PLL1};
        new_src_d = src_ext(target, j16_db);
        state_d = SETTLE1;
      end
      SETTLE1, SETTLE2: begin
        cnt_d = settle_done ? 8'd0 : cnt + 8'd1;
        state_d = !settle_done ? state : state == SETTLE1 ? APPLY : RESTORE;
      end
      APPLY: begin
        clock_reg_d = {2'b00, new_src ? CLK_EXT : CLK_PLL1};
        state_d = SETTLE2;
      end
      RESTORE: begin
        clock_reg_d = target;
        j16_d = j16_db;
        k16_d = k16_db;
        count_d = O_switch_count + 8'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_clock_sel_ctrl.sv
// tb_clock_sel_ctrl: directed and randomized checks of clock_sel_ctrl against a behavioural switch model
module tb_clock_sel_ctrl;
  localparam int S = 4;
  localparam int D = 20;
  localparam logic [7:0] RA = 8'h0C;
  logic clk = 1'b0, rst_n = 1'b0, j16_raw = 1'b0, k16_raw = 1'b0;
  logic [4:0] clock_reg;
  logic j16_sel, k16_sel, busy;
  logic [7:0] sw_cnt;
  int checks = 0, failures = 0, bcnt = 0;
  logic [4:0] seq[$];
  clock_sel_ctrl_if bus();
  clock_sel_ctrl #(.DEBOUNCE_CYCLES(16'(D)), .SETTLE_CYCLES(8'(S))) dut (
    .usb_clk(clk), .rst_n(rst_n), .bus(bus), .j16_raw(j16_raw), .k16_raw(k16_raw),
    .O_clock_reg(clock_reg), .O_j16_sel(j16_sel), .O_k16_sel(k16_sel), .O_busy(busy),
    .O_switch_count(sw_cnt)
  );
  always #5 clk = ~clk;
  function automatic logic ref_src(input logic [4:0] r, input logic j);
    if (r[2:0] == 3'd1) return 1'b0;
    if (r[2:0] == 3'd5) return 1'b1;
    return r[0] == 1'b0 && j;
  endfunction
  function automatic logic [31:0] pk(input logic [4:0] q[$]);
    logic [31:0] v = 32'd1;
    foreach (q[i]) v = (v << 5) | 32'(q[i]);
    return v;
  endfunction
  function automatic logic [31:0] expect_seq(input logic [4:0] old, input logic [4:0] nw, input logic j);
    logic [4:0] c[$];
    logic [4:0] q[$];
    q.push_back(old);
    if (ref_src(old, j) != ref_src(nw, j)) begin
      c.push_back(ref_src(old, j) ? 5'd5 : 5'd1);
      c.push_back(ref_src(nw, j) ? 5'd5 : 5'd1);
    end
    c.push_back(nw);
    foreach (c[i]) if (c[i] != q[$]) q.push_back(c[i]);
    return pk(q);
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic start();
    seq.delete();
    seq.push_back(clock_reg);
    bcnt = 0;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    bcnt += int'(busy);
    if (clock_reg != seq[$]) seq.push_back(clock_reg);
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.reg_addr = a;
    bus.reg_datai = d;
    bus.reg_write = 1'b1;
    tick();
    bus.reg_write = 1'b0;
  endtask
  task automatic rd(input logic [7:0] a);
    bus.reg_addr = a;
    bus.reg_read = 1'b1;
    tick();
    bus.reg_read = 1'b0;
  endtask
  initial begin
    logic [4:0] applied, nt;
    logic [7:0] d, v;
    logic sw;
    int mc;
    bus.reg_addr = '0;
    bus.reg_datai = '0;
    bus.reg_write = 1'b0;
    bus.reg_read = 1'b0;
    #1;
    start();
    repeat (3) tick();
    chk("rst_clock_reg", 32'(clock_reg), 32'h01);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_count", 32'(sw_cnt), 32'h0);
    chk("rst_sel", 32'({j16_sel, k16_sel}), 32'h0);
    chk("rst_datao", 32'(bus.reg_datao), 32'h0);
    #2 rst_n = 1'b1;
    tick();
    rd(RA);
    chk("read_reset", 32'(bus.reg_datao), 32'h01);
    rd(8'h0D);
    chk("read_other_addr", 32'(bus.reg_datao), 32'h00);
    start();
    wr(8'h0B, 8'h0D);
    repeat (3) tick();
    chk("wrong_addr_clock_reg", 32'(clock_reg), 32'h01);
    chk("wrong_addr_busy", 32'(bcnt), 32'h0);
    start();
    wr(RA, 8'h09);
    tick();
    chk("apply_09", 32'(clock_reg), 32'h09);
    wr(RA, 8'h01);
    tick();
    chk("apply_01", 32'(clock_reg), 32'h01);
    repeat (3) tick();
    chk("apply_no_busy", 32'(bcnt), 32'h0);
    chk("apply_count", 32'(sw_cnt), 32'h0);
    start();
    wr(RA, 8'h0D);
    tick();
    chk("gate_busy_rise", 32'(busy), 32'h1);
    chk("gate_clock_reg", 32'(clock_reg), 32'h01);
    repeat (14) tick();
    chk("sw1_busy_cycles", 32'(bcnt), 32'd11);
    chk("sw1_seq", pk(seq), 32'({1'b1, 5'h01, 5'h05, 5'h0D}));
    chk("sw1_count", 32'(sw_cnt), 32'd1);
    start();
    wr(RA, 8'h01);
    repeat (14) tick();
    chk("sw2_busy_cycles", 32'(bcnt), 32'd11);
    chk("sw2_seq", pk(seq), 32'({1'b1, 5'h0D, 5'h05, 5'h01}));
    chk("sw2_count", 32'(sw_cnt), 32'd2);
    start();
    wr(RA, 8'h0D);
    repeat (2) tick();
    wr(RA, 8'h01);
    rd(RA);
    chk("read_busy", 32'(bus.reg_datao), 32'h81);
    repeat (12) tick();
    chk("settle1_write_busy", 32'(bcnt), 32'd11);
    chk("settle1_write_seq", pk(seq), 32'({1'b1, 5'h01, 5'h05, 5'h01}));
    chk("settle1_write_count", 32'(sw_cnt), 32'd3);
    start();
    wr(RA, 8'h0D);
    repeat (11) tick();
    wr(RA, 8'h01);
    repeat (14) tick();
    chk("reentry_busy", 32'(bcnt), 32'd22);
    chk("reentry_seq", pk(seq), 32'({1'b1, 5'h01, 5'h05, 5'h0D, 5'h05, 5'h01}));
    chk("reentry_count", 32'(sw_cnt), 32'd5);
    chk("reentry_clock_reg", 32'(clock_reg), 32'h01);
    wr(RA, 8'h00);
    tick();
    chk("apply_00", 32'(clock_reg), 32'h00);
    j16_raw = 1'b1;
    repeat (10) tick();
    j16_raw = 1'b0;
    start();
    repeat (30) tick();
    chk("glitch_j16_sel", 32'(j16_sel), 32'h0);
    chk("glitch_busy", 32'(bcnt), 32'h0);
    j16_raw = 1'b1;
    start();
    repeat (60) tick();
    chk("dip_busy", 32'(bcnt), 32'd11);
    chk("dip_seq", pk(seq), 32'({1'b1, 5'h00, 5'h01, 5'h05, 5'h00}));
    chk("dip_j16_sel", 32'(j16_sel), 32'h1);
    chk("dip_count", 32'(sw_cnt), 32'd6);
    k16_raw = 1'b1;
    start();
    repeat (30) tick();
    chk("dip_k16_sel", 32'(k16_sel), 32'h1);
    chk("dip_k16_busy", 32'(bcnt), 32'h0);
    applied = 5'h00;
    mc = 6;
    for (int i = 0; i < 20; i++) begin
      d = 8'($urandom);
      nt = d[4:0];
      sw = ref_src(nt, 1'b1) != ref_src(applied, 1'b1);
      start();
      wr(RA, d);
      repeat (14) tick();
      mc += int'(sw);
      chk($sformatf("rnd%0d_busy", i), 32'(bcnt), sw ? 32'd11 : 32'd0);
      chk($sformatf("rnd%0d_seq", i), pk(seq), expect_seq(applied, nt, 1'b1));
      chk($sformatf("rnd%0d_count", i), 32'(sw_cnt), 32'(mc[7:0]));
      rd(RA);
      chk($sformatf("rnd%0d_read", i), 32'(bus.reg_datao), 32'(nt));
      applied = nt;
    end
    v = ref_src(applied, 1'b1) ? 8'h01 : 8'h0D;
    wr(RA, v);
    repeat (8) tick();
    chk("pre_reset_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_clock_reg", 32'(clock_reg), 32'h01);
    chk("async_busy", 32'(busy), 32'h0);
    chk("async_count", 32'(sw_cnt), 32'h0);
    chk("async_sel", 32'({j16_sel, k16_sel}), 32'h0);
    chk("async_datao", 32'(bus.reg_datao), 32'h0);
    j16_raw = 1'b0;
    k16_raw = 1'b0;
    #1 rst_n = 1'b1;
    tick();
    rd(RA);
    chk("post_reset_read", 32'(bus.reg_datao), 32'h01);
    start();
    repeat (40) tick();
    chk("post_reset_idle", 32'(bcnt), 32'h0);
    chk("post_reset_clock_reg", 32'(clock_reg), 32'h01);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
